// File: rtl/imm_pkg.sv
// Shared definitions for the RISC-V immediate generator.
// Contents:
//   IMM_I/IMM_S/IMM_B/IMM_J - imm_src format-select encodings.
//   sign_fill               - helper that replicates the instruction sign bit.
package imm_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Returns a 20-bit field filled with the sign bit. Narrower fills are
  // taken as slices of this result.
  function automatic logic [19:0] sign_fill(input logic s);
    return {20{s}};
  endfunction

endpackage

// File: rtl/imm_extend_comb.sv
// Purely combinational immediate format mux.
// Optional feature: define IMM_EXTEND_UTYPE_EN to add the utype override input.
// Ports:
//   instr   [31:7] in  - instruction bits 31..7; bit k is instruction bit k
//   imm_src [1:0]  in  - format select: 00 I, 01 S, 10 B, 11 J
//   utype          in  - (IMM_EXTEND_UTYPE_EN only) forces U-type, overrides imm_src
//   imm     [31:0] out - sign-extended immediate
module imm_extend_comb
  import imm_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [1:0]  imm_src,
`ifdef IMM_EXTEND_UTYPE_EN
  input  logic        utype,
`endif
  output logic [31:0] imm
);

  logic        s;
  logic [19:0] fill;

  assign s    = instr[31];
  assign fill = sign_fill(s);

  always_comb begin
    imm = '0;
`ifdef IMM_EXTEND_UTYPE_EN
    if (utype) begin
      imm = {instr[31:12], 12'h000};
    end else begin
`endif
      // All four codes are listed, so the mux never yields X for a known select.
      case (imm_src)
        IMM_I: imm = {fill, instr[31:20]};
        IMM_S: imm = {fill, instr[31:25], instr[11:7]};
        IMM_B: imm = {fill[18:0], s, instr[7], instr[30:25], instr[11:8], 1'b0};
        IMM_J: imm = {fill[10:0], s, instr[19:12], instr[20], instr[30:21], 1'b0};
      endcase
`ifdef IMM_EXTEND_UTYPE_EN
    end
`endif
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered RISC-V immediate generator for the decode stage.
// Optional feature: define IMM_EXTEND_UTYPE_EN to add the utype input.
// Ports:
//   clk            in  - rising-edge pipeline clock
//   rst_n          in  - synchronous active-low reset (priority over stall)
//   stall          in  - hold output registers
//   in_valid       in  - instr/imm_src are valid this cycle
//   instr   [31:7] in  - instruction bits 31..7; bit k is instruction bit k
//   imm_src [1:0]  in  - format select: 00 I, 01 S, 10 B, 11 J
//   utype          in  - (IMM_EXTEND_UTYPE_EN only) U-type override
//   imm_ext [XLEN-1:0] out - registered sign-extended immediate
//   out_valid      out - imm_ext was captured from a valid input
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [31:7]     instr,
  input  logic [1:0]      imm_src,
`ifdef IMM_EXTEND_UTYPE_EN
  input  logic            utype,
`endif
  output logic [XLEN-1:0] imm_ext,
  output logic            out_valid
);

  if (XLEN != 32) begin : g_xlen_check
    $error("imm_extend_unit: only XLEN=32 is supported");
  end

  logic [31:0] imm_next;

  imm_extend_comb u_comb (
    .instr   (instr),
    .imm_src (imm_src),
`ifdef IMM_EXTEND_UTYPE_EN
    .utype   (utype),
`endif
    .imm     (imm_next)
  );

  // The immediate is captured even for invalid inputs; out_valid alone
  // qualifies it, which keeps the data path free of an enable on in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_ext   <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      imm_ext   <= imm_next;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        in_valid;
  logic [31:7] instr;
  logic [1:0]  imm_src;
`ifdef IMM_EXTEND_UTYPE_EN
  logic        utype;
`endif
  logic [31:0] imm_ext;
  logic        out_valid;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  imm_extend_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .in_valid  (in_valid),
    .instr     (instr),
    .imm_src   (imm_src),
`ifdef IMM_EXTEND_UTYPE_EN
    .utype     (utype),
`endif
    .imm_ext   (imm_ext),
    .out_valid (out_valid)
  );

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b1;
    instr    = 25'h1FFFFFF;
    imm_src  = 2'b00;
    step();
    step();
    vectors++;
    if (imm_ext !== 32'h0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: imm_ext=%h out_valid=%b, expected 00000000/0", imm_ext, out_valid);
    end
    // Release: the very next edge captures the applied S-type vector.
    rst_n   = 1'b1;
    instr   = 25'h1FC0004;
    imm_src = 2'b01;
    step();
    vectors++;
    if (imm_ext !== 32'hFFFFFFE4 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: imm_ext=%h out_valid=%b, expected ffffffe4/1", imm_ext, out_valid);
    end
  endtask

  task automatic test_formats();
    logic [24:0] t_instr [7];
    logic [1:0]  t_src   [7];
    logic [31:0] t_exp   [7];
    t_instr[0] = 25'h1FFFFFF; t_src[0] = 2'b00; t_exp[0] = 32'hFFFFFFFF;
    t_instr[1] = 25'h1FC0004; t_src[1] = 2'b01; t_exp[1] = 32'hFFFFFFE4;
    t_instr[2] = 25'h0400808; t_src[2] = 2'b10; t_exp[2] = 32'h00000208;
    t_instr[3] = 25'h0010000; t_src[3] = 2'b11; t_exp[3] = 32'h00000008;
    t_instr[4] = 25'h1000000; t_src[4] = 2'b11; t_exp[4] = 32'hFFF00000;
    // I positive: instr[31:20]=0x7FF
    t_instr[5] = 25'h0FFE000; t_src[5] = 2'b00; t_exp[5] = 32'h000007FF;
    // B with sign and instr[7]: 0x1000001 -> s=1, bit11=1
    t_instr[6] = 25'h1000001; t_src[6] = 2'b10; t_exp[6] = 32'hFFFFF800;
    in_valid = 1'b1;
    stall    = 1'b0;
    for (int i = 0; i < 7; i++) begin
      instr   = t_instr[i];
      imm_src = t_src[i];
      step();
      vectors++;
      if (imm_ext !== t_exp[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL format[%0d] src=%b: imm_ext=%h out_valid=%b, expected %h/1",
                 i, t_src[i], imm_ext, out_valid, t_exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    in_valid = 1'b1;
    stall    = 1'b0;
    instr    = 25'h1FFFFFF;
    imm_src  = 2'b00;
    step();
    stall   = 1'b1;
    instr   = 25'h1FC0004;
    imm_src = 2'b01;
    for (int c = 0; c < 3; c++) begin
      in_valid = (c != 1);
      step();
      vectors++;
      if (imm_ext !== 32'hFFFFFFFF || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: imm_ext=%h out_valid=%b, expected ffffffff/1", c, imm_ext, out_valid);
      end
    end
    stall    = 1'b0;
    in_valid = 1'b1;
    step();
    vectors++;
    if (imm_ext !== 32'hFFFFFFE4 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: imm_ext=%h out_valid=%b, expected ffffffe4/1", imm_ext, out_valid);
    end
  endtask

  task automatic test_invalid();
    stall    = 1'b0;
    in_valid = 1'b0;
    instr    = 25'h0400808;
    imm_src  = 2'b10;
    step();
    vectors++;
    if (out_valid !== 1'b0 || imm_ext !== 32'h00000208) begin
      miscompares++;
      $display("FAIL invalid_capture: imm_ext=%h out_valid=%b, expected 00000208/0", imm_ext, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    stall    = 1'b0;
    in_valid = 1'b1;
    instr    = 25'h1000000;
    imm_src  = 2'b11;
    step();
    // Reset wins over stall and discards the held result.
    rst_n = 1'b0;
    stall = 1'b1;
    step();
    vectors++;
    if (imm_ext !== 32'h0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: imm_ext=%h out_valid=%b, expected 00000000/0", imm_ext, out_valid);
    end
    // After release, a stalled valid input must not produce output.
    rst_n = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || imm_ext !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_stall: imm_ext=%h out_valid=%b, expected 00000000/0", imm_ext, out_valid);
    end
    stall = 1'b0;
    step();
    vectors++;
    if (imm_ext !== 32'hFFF00000 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_first: imm_ext=%h out_valid=%b, expected fff00000/1", imm_ext, out_valid);
    end
  endtask

`ifdef IMM_EXTEND_UTYPE_EN
  task automatic test_utype();
    stall    = 1'b0;
    in_valid = 1'b1;
    utype    = 1'b1;
    instr    = {20'h12345, 5'b00000};
    imm_src  = 2'b10;
    step();
    vectors++;
    if (imm_ext !== 32'h12345000 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL utype: imm_ext=%h out_valid=%b, expected 12345000/1", imm_ext, out_valid);
    end
    utype = 1'b0;
    step();
    // B-type of {0x12345,0}: s=0, instr[7]=0, instr[30:25]=0x09, instr[11:8]=0
    vectors++;
    if (imm_ext !== 32'h00000120) begin
      miscompares++;
      $display("FAIL utype_off: imm_ext=%h, expected 00000120", imm_ext);
    end
  endtask
`endif

  initial begin
`ifdef IMM_EXTEND_UTYPE_EN
    utype = 1'b0;
`endif
    #2;
    test_reset();
    test_formats();
    test_stall();
    test_invalid();
    test_mid_reset();
`ifdef IMM_EXTEND_UTYPE_EN
    test_utype();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
